flex_counter_array: RTL and testbench

//  NUM_CH independent, parametrised counters in one block, successor to the single-channel flex counter.

---
 rtl/flex_counter_pkg.sv | 36 +++
 rtl/flex_counter_array_if.sv | 26 ++
 rtl/flex_counter_chan.sv | 62 ++++++
 rtl/flex_counter_array.sv | 60 ++++++
 tb/tb_flex_counter_array.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/flex_counter_pkg.sv
// rtl/flex_counter_pkg.sv - shared types and step function for the flex counter array
package flex_counter_pkg;

    typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;
    typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_t;

    // Channel counts are zero-extended into this width so the +1/-1 steps never alias.
    localparam int CNT_MAX_W = 32;
    typedef logic [CNT_MAX_W-1:0] cnt_word_t;

    function automatic cnt_word_t next_count(input cnt_word_t count, input cnt_word_t rv,
                                             input cnt_dir_t dir, input cnt_mode_t mode);
        if (rv == '0) begin
            return '0;
        end
        if (dir == CNT_UP) begin
            if (count >= rv) begin
                return (mode == CNT_SAT) ? rv : cnt_word_t'(1);
            end
            return count + cnt_word_t'(1);
        end
        if (count <= cnt_word_t'(1)) begin
            return (mode == CNT_SAT) ? cnt_word_t'(1) : rv;
        end
        return count - cnt_word_t'(1);
    endfunction

    function automatic logic is_wrap(input cnt_word_t count, input cnt_word_t rv,
                                     input cnt_dir_t dir, input cnt_mode_t mode);
        if (rv == '0 || mode == CNT_SAT) begin
            return 1'b0;
        end
        return (dir == CNT_UP) ? (count >= rv) : (count <= cnt_word_t'(1));
    endfunction

endpackage

// File: rtl/flex_counter_array_if.sv
// rtl/flex_counter_array_if.sv - control and status bundle of the flex counter array
interface flex_counter_array_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
);
    logic [NUM_CH-1:0]              clear;
    logic [NUM_CH-1:0]              count_enable;
    logic [NUM_CH-1:0]              load;
    logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CH-1:0]              mode_down;
    logic [NUM_CH-1:0]              mode_sat;
    logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CH-1:0]              rollover_flag;
    logic [NUM_CH-1:0]              wrap_pulse;

    modport master (
        output clear, count_enable, load, load_val, rollover_val, mode_down, mode_sat,
        input  count_out, rollover_flag, wrap_pulse
    );

    modport slave (
        input  clear, count_enable, load, load_val, rollover_val, mode_down, mode_sat,
        output count_out, rollover_flag, wrap_pulse
    );
endinterface

// File: rtl/flex_counter_chan.sv
// rtl/flex_counter_chan.sv - one counter channel: next-state logic, count and flag registers
module flex_counter_chan
    import flex_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] rollover_val,
    input  logic         mode_down,
    input  logic         mode_sat,
    output logic [W-1:0] count_out,
    output logic         rollover_flag,
    output logic         wrap_event
);
    cnt_dir_t     dir;
    cnt_mode_t    mode;
    logic [W-1:0] terminal;
    logic         rv_nz;
    logic [W-1:0] count_q, count_d;
    logic         flag_q, flag_d;

    assign dir      = mode_down ? CNT_DOWN : CNT_UP;
    assign mode     = mode_sat ? CNT_SAT : CNT_WRAP;
    assign terminal = mode_down ? W'(1) : rollover_val;
    assign rv_nz    = (rollover_val != '0);

    // A zero rollover value is degenerate: the flag is never raised for it.
    always_comb begin
        count_d    = count_q;
        flag_d     = rv_nz && (count_q == terminal);
        wrap_event = 1'b0;
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            flag_d  = rv_nz && (load_val == terminal);
        end else if (enable) begin
            count_d    = W'(next_count(cnt_word_t'(count_q), cnt_word_t'(rollover_val), dir, mode));
            flag_d     = rv_nz && (count_d == terminal);
            wrap_event = is_wrap(cnt_word_t'(count_q), cnt_word_t'(rollover_val), dir, mode);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;
endmodule

// File: rtl/flex_counter_array.sv
// rtl/flex_counter_array.sv - NUM_CH flex counters with optional wrap-driven cascade chain
module flex_counter_array
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter int CASCADE      = 0
) (
    input logic                clk,
    input logic                n_rst,
    flex_counter_array_if.slave bus
);
    localparam int W = NUM_CNT_BITS;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic         en_eff;
        logic         wrap_ev;
        logic         flag;
        logic [W-1:0] cnt;
        logic         pulse_q, pulse_d;

        // Cascaded channels advance only in the cycle the previous channel wraps.
        if (CASCADE != 0 && i > 0) begin : g_casc
            assign en_eff = bus.count_enable[i] & g_ch[i-1].wrap_ev;
        end else begin : g_solo
            assign en_eff = bus.count_enable[i];
        end

        flex_counter_chan #(.W(W)) u_chan (
            .clk          (clk),
            .n_rst        (n_rst),
            .clear        (bus.clear[i]),
            .enable       (en_eff),
            .load         (bus.load[i]),
            .load_val     (bus.load_val[i*W +: W]),
            .rollover_val (bus.rollover_val[i*W +: W]),
            .mode_down    (bus.mode_down[i]),
            .mode_sat     (bus.mode_sat[i]),
            .count_out    (cnt),
            .rollover_flag(flag),
            .wrap_event   (wrap_ev)
        );

        always_comb begin
            pulse_d = wrap_ev;
        end

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= pulse_d;
            end
        end

        assign bus.count_out[i*W +: W] = cnt;
        assign bus.rollover_flag[i]    = flag;
        assign bus.wrap_pulse[i]       = pulse_q;
    end
endmodule

// File: tb/tb_flex_counter_array.sv
// tb/tb_flex_counter_array.sv - directed bench for flex_counter_array, plain and cascaded
module tb_flex_counter_array;
    logic clk = 1'b0;
    logic n_rst;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    flex_counter_array_if #(.NUM_CNT_BITS(4), .NUM_CH(2)) a_if ();
    flex_counter_array_if #(.NUM_CNT_BITS(4), .NUM_CH(2)) b_if ();

    flex_counter_array #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .bus(a_if.slave)
    );
    flex_counter_array #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .bus(b_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int c, input int f, input int p);
        chk({tag, ".count"}, 32'(a_if.count_out[3:0]), 32'(c));
        chk({tag, ".flag"},  32'(a_if.rollover_flag[0]), 32'(f));
        chk({tag, ".pulse"}, 32'(a_if.wrap_pulse[0]), 32'(p));
    endtask

    task automatic chk_b(input string tag, input int c0, input int c1, input int f, input int p);
        chk({tag, ".ch0"},   32'(b_if.count_out[3:0]), 32'(c0));
        chk({tag, ".ch1"},   32'(b_if.count_out[7:4]), 32'(c1));
        chk({tag, ".flag"},  32'(b_if.rollover_flag), 32'(f));
        chk({tag, ".pulse"}, 32'(b_if.wrap_pulse), 32'(p));
    endtask

    int exp_c[6] = '{1, 2, 3, 4, 5, 1};
    int exp_f[6] = '{0, 0, 0, 0, 1, 0};
    int exp_p[6] = '{0, 0, 0, 0, 0, 1};
    int sat_c[8] = '{1, 2, 3, 3, 3, 2, 1, 1};
    int sat_f[8] = '{0, 0, 1, 1, 1, 0, 1, 1};

    initial begin
        n_rst = 1'b0;
        a_if.clear = '0; a_if.count_enable = '0; a_if.load = '0; a_if.load_val = '0;
        a_if.rollover_val = 8'h55; a_if.mode_down = '0; a_if.mode_sat = '0;
        b_if.clear = '0; b_if.count_enable = '0; b_if.load = '0; b_if.load_val = '0;
        b_if.rollover_val = {4'd5, 4'd9}; b_if.mode_down = '0; b_if.mode_sat = '0;

        repeat (2) tick();
        chk_a("reset", 0, 0, 0);
        chk_b("reset_b", 0, 0, 0, 0);
        n_rst = 1'b1;

        a_if.count_enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_a($sformatf("upwrap%0d", k), exp_c[k], exp_f[k], exp_p[k]);
        end

        repeat (3) tick();
        chk_a("pre_reset", 4, 0, 0);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk_a("async_reset", 0, 0, 0);
        tick();
        n_rst = 1'b1;
        tick();
        chk_a("resume", 1, 0, 0);

        a_if.count_enable[0] = 1'b0;
        a_if.clear[0] = 1'b1;
        tick();
        chk_a("clear", 0, 0, 0);
        a_if.clear[0] = 1'b0;
        a_if.rollover_val[3:0] = 4'd3;
        a_if.mode_sat[0] = 1'b1;
        a_if.count_enable[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) a_if.mode_down[0] = 1'b1;
            tick();
            chk_a($sformatf("sat%0d", k), sat_c[k], sat_f[k], 0);
        end

        a_if.mode_down[0] = 1'b0;
        a_if.mode_sat[0] = 1'b0;
        a_if.clear[0] = 1'b1;
        a_if.load[0] = 1'b1;
        a_if.load_val[3:0] = 4'd7;
        tick();
        chk_a("prio_clear", 0, 0, 0);
        a_if.clear[0] = 1'b0;
        tick();
        chk_a("prio_load", 7, 0, 0);
        a_if.load[0] = 1'b0;
        tick();
        chk_a("rv_below", 1, 0, 1);

        a_if.rollover_val[3:0] = 4'd15;
        a_if.load_val[3:0] = 4'd15;
        a_if.load[0] = 1'b1;
        tick();
        chk_a("load15", 15, 1, 0);
        a_if.load[0] = 1'b0;
        tick();
        chk_a("wrap15", 1, 0, 1);
        a_if.rollover_val[3:0] = 4'd0;
        tick();
        chk_a("rv0_a", 0, 0, 0);
        tick();
        chk_a("rv0_b", 0, 0, 0);

        b_if.load = 2'b11;
        b_if.load_val = {4'd1, 4'd1};
        tick();
        chk_b("casc_load", 1, 1, 0, 0);
        b_if.load = 2'b00;
        b_if.count_enable = 2'b11;
        repeat (8) tick();
        chk_b("casc8", 9, 1, 1, 0);
        tick();
        chk_b("casc9", 1, 2, 0, 1);
        repeat (35) tick();
        chk_b("casc44", 9, 5, 3, 0);
        tick();
        chk_b("casc45", 1, 1, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
